// File: rtl/tx_fifo_ptr_ctrl.sv
// Head/tail pointer controller for the TX buffer RAM.
// Any depth 2..256, wrap toggles, occupancy, status and sticky error flags.
module tx_fifo_ptr_ctrl #(
  parameter int DEPTH     = 6,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH + 1),
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tx_enq,
  input  logic             tx_deq,
  output logic             enq_ok,
  output logic             deq_ok,
  output logic [PTR_W-1:0] tail_ptr,
  output logic             tail_tog,
  output logic [PTR_W-1:0] head_ptr,
  output logic             head_tog,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W-1:0] P_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] P_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] C_AE   = CNT_W'(AE_THRESH);

  logic ptr_eq;

  // Flags come only from registered state, never from the requests.
  assign ptr_eq       = (head_ptr == tail_ptr);
  assign empty        = ptr_eq & (head_tog == tail_tog);
  assign full         = ptr_eq & (head_tog != tail_tog);
  assign almost_full  = (count >= C_AF);
  assign almost_empty = (count <= C_AE);

  assign enq_ok = tx_enq & ~full & ~clear;
  assign deq_ok = tx_deq & ~empty & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_ptr  <= '0;
      tail_tog  <= 1'b0;
      head_ptr  <= '0;
      head_tog  <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      tail_ptr  <= '0;
      tail_tog  <= 1'b0;
      head_ptr  <= '0;
      head_tog  <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (enq_ok) begin
        if (tail_ptr == P_LAST) begin
          tail_ptr <= '0;
          tail_tog <= ~tail_tog;
        end else begin
          tail_ptr <= tail_ptr + P_ONE;
        end
      end
      if (deq_ok) begin
        if (head_ptr == P_LAST) begin
          head_ptr <= '0;
          head_tog <= ~head_tog;
        end else begin
          head_ptr <= head_ptr + P_ONE;
        end
      end
      unique case ({enq_ok, deq_ok})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
      overflow  <= overflow | (tx_enq & full);
      underflow <= underflow | (tx_deq & empty);
    end
  end

endmodule

// File: tb/tb_tx_fifo_ptr_ctrl.sv
// Directed bench for tx_fifo_ptr_ctrl.
// DEPTH=6 main instance plus DEPTH=8 and DEPTH=2 fill/wrap instances.
module tb_tx_fifo_ptr_ctrl;

  logic clk, rst, clear;
  int total, bad;

  logic enq6, deq6, eok6, dok6, ttog6, htog6;
  logic [2:0] tptr6, hptr6, cnt6;
  logic full6, empty6, af6, ae6, ovf6, unf6;

  logic enq8, eok8, dok8, ttog8, htog8;
  logic [2:0] tptr8, hptr8;
  logic [3:0] cnt8;
  logic full8, empty8, af8, ae8, ovf8, unf8;

  logic enq2, eok2, dok2, ttog2, htog2;
  logic [0:0] tptr2, hptr2;
  logic [1:0] cnt2;
  logic full2, empty2, af2, ae2, ovf2, unf2;

  tx_fifo_ptr_ctrl #(.DEPTH(6)) u_d6 (
    .clk(clk), .rst(rst), .clear(clear),
    .tx_enq(enq6), .tx_deq(deq6),
    .enq_ok(eok6), .deq_ok(dok6),
    .tail_ptr(tptr6), .tail_tog(ttog6),
    .head_ptr(hptr6), .head_tog(htog6),
    .count(cnt6), .full(full6), .empty(empty6),
    .almost_full(af6), .almost_empty(ae6),
    .overflow(ovf6), .underflow(unf6)
  );

  tx_fifo_ptr_ctrl #(.DEPTH(8)) u_d8 (
    .clk(clk), .rst(rst), .clear(clear),
    .tx_enq(enq8), .tx_deq(1'b0),
    .enq_ok(eok8), .deq_ok(dok8),
    .tail_ptr(tptr8), .tail_tog(ttog8),
    .head_ptr(hptr8), .head_tog(htog8),
    .count(cnt8), .full(full8), .empty(empty8),
    .almost_full(af8), .almost_empty(ae8),
    .overflow(ovf8), .underflow(unf8)
  );

  tx_fifo_ptr_ctrl #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .clear(clear),
    .tx_enq(enq2), .tx_deq(1'b0),
    .enq_ok(eok2), .deq_ok(dok2),
    .tail_ptr(tptr2), .tail_tog(ttog2),
    .head_ptr(hptr2), .head_tog(htog2),
    .count(cnt2), .full(full2), .empty(empty2),
    .almost_full(af2), .almost_empty(ae2),
    .overflow(ovf2), .underflow(unf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One cycle on the DEPTH=6 instance; returns at posedge+1.
  task automatic cyc6(input logic e, input logic d);
    enq6 = e;
    deq6 = d;
    @(posedge clk);
    #1;
    enq6 = 1'b0;
    deq6 = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear = 1'b0;
    enq6  = 1'b0;
    deq6  = 1'b0;
    enq8  = 1'b0;
    enq2  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_cnt", int'(cnt6), 0);
    chk("rst_empty", int'(empty6), 1);
    chk("rst_full", int'(full6), 0);
    chk("rst_ae", int'(ae6), 1);
    chk("rst_af", int'(af6), 0);
    chk("rst_ovf", int'(ovf6), 0);

    // Fill DEPTH=6
    for (int i = 0; i < 6; i++) begin
      chk("fill_tail", int'(tptr6), i);
      enq6 = 1'b1;
      #1;
      chk("fill_eok", int'(eok6), 1);
      @(posedge clk);
      #1;
      enq6 = 1'b0;
      chk("fill_cnt", int'(cnt6), i + 1);
      chk("fill_af", int'(af6), (i + 1 >= 5) ? 1 : 0);
      chk("fill_ae", int'(ae6), (i + 1 <= 1) ? 1 : 0);
    end
    chk("fill_tail_end", int'(tptr6), 0);
    chk("fill_ttog", int'(ttog6), 1);
    chk("fill_full", int'(full6), 1);
    chk("fill_empty", int'(empty6), 0);

    // Overflow while full
    enq6 = 1'b1;
    #1;
    chk("ovf_eok", int'(eok6), 0);
    @(posedge clk);
    #1;
    enq6 = 1'b0;
    chk("ovf_tail", int'(tptr6), 0);
    chk("ovf_cnt", int'(cnt6), 6);
    chk("ovf_set", int'(ovf6), 1);
    cyc6(1'b0, 1'b0);
    chk("ovf_sticky", int'(ovf6), 1);

    // Clear, with a request in the same cycle that must be ignored
    enq6  = 1'b1;
    clear = 1'b1;
    #1;
    chk("clr_eok", int'(eok6), 0);
    @(posedge clk);
    #1;
    enq6  = 1'b0;
    clear = 1'b0;
    chk("clr_ovf", int'(ovf6), 0);
    chk("clr_empty", int'(empty6), 1);
    chk("clr_tail", int'(tptr6), 0);
    chk("clr_head", int'(hptr6), 0);
    chk("clr_ttog", int'(ttog6), 0);
    chk("clr_cnt", int'(cnt6), 0);

    // Refill, then drain seven times
    repeat (6) cyc6(1'b1, 1'b0);
    chk("refill_full", int'(full6), 1);
    for (int i = 0; i < 7; i++) begin
      deq6 = 1'b1;
      #1;
      if (i < 6) begin
        chk("drain_head", int'(hptr6), i);
        chk("drain_dok", int'(dok6), 1);
      end else begin
        chk("drain_dok7", int'(dok6), 0);
      end
      @(posedge clk);
      #1;
      deq6 = 1'b0;
      if (i == 5) begin
        chk("drain_empty6", int'(empty6), 1);
        chk("drain_unf6", int'(unf6), 0);
      end
    end
    chk("drain_head_end", int'(hptr6), 0);
    chk("drain_htog", int'(htog6), 1);
    chk("drain_unf", int'(unf6), 1);
    chk("drain_cnt", int'(cnt6), 0);

    // Simultaneous at count=3: head=2, tail=5
    do_clear();
    repeat (5) cyc6(1'b1, 1'b0);
    repeat (2) cyc6(1'b0, 1'b1);
    chk("sim_pre_cnt", int'(cnt6), 3);
    for (int i = 0; i < 4; i++) begin
      enq6 = 1'b1;
      deq6 = 1'b1;
      #1;
      chk("sim_eok", int'(eok6), 1);
      chk("sim_dok", int'(dok6), 1);
      @(posedge clk);
      #1;
      enq6 = 1'b0;
      deq6 = 1'b0;
      chk("sim_cnt", int'(cnt6), 3);
    end
    chk("sim_tail", int'(tptr6), 3);
    chk("sim_head", int'(hptr6), 0);
    chk("sim_ttog", int'(ttog6), 1);
    chk("sim_htog", int'(htog6), 1);

    // Edge simultaneity at empty and at full
    do_clear();
    enq6 = 1'b1;
    deq6 = 1'b1;
    #1;
    chk("edge_e_eok", int'(eok6), 1);
    chk("edge_e_dok", int'(dok6), 0);
    @(posedge clk);
    #1;
    enq6 = 1'b0;
    deq6 = 1'b0;
    chk("edge_e_cnt", int'(cnt6), 1);
    chk("edge_e_unf", int'(unf6), 1);
    repeat (5) cyc6(1'b1, 1'b0);
    chk("edge_f_full", int'(full6), 1);
    enq6 = 1'b1;
    deq6 = 1'b1;
    #1;
    chk("edge_f_eok", int'(eok6), 0);
    chk("edge_f_dok", int'(dok6), 1);
    @(posedge clk);
    #1;
    enq6 = 1'b0;
    deq6 = 1'b0;
    chk("edge_f_ovf", int'(ovf6), 1);
    chk("edge_f_cnt", int'(cnt6), 5);

    // Async reset between edges at count=4
    cyc6(1'b0, 1'b1);
    chk("ar_pre_cnt", int'(cnt6), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_cnt", int'(cnt6), 0);
    chk("ar_tail", int'(tptr6), 0);
    chk("ar_head", int'(hptr6), 0);
    chk("ar_htog", int'(htog6), 0);
    chk("ar_ovf", int'(ovf6), 0);
    chk("ar_unf", int'(unf6), 0);
    chk("ar_empty", int'(empty6), 1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill DEPTH=8
    for (int i = 0; i < 8; i++) begin
      chk("d8_tail", int'(tptr8), i);
      enq8 = 1'b1;
      @(posedge clk);
      #1;
      enq8 = 1'b0;
    end
    chk("d8_tail_end", int'(tptr8), 0);
    chk("d8_ttog", int'(ttog8), 1);
    chk("d8_full", int'(full8), 1);
    chk("d8_cnt", int'(cnt8), 8);

    // Fill DEPTH=2
    for (int i = 0; i < 2; i++) begin
      chk("d2_tail", int'(tptr2), i);
      chk("d2_af", int'(af2), (i >= 1) ? 1 : 0);
      enq2 = 1'b1;
      @(posedge clk);
      #1;
      enq2 = 1'b0;
    end
    chk("d2_tail_end", int'(tptr2), 0);
    chk("d2_ttog", int'(ttog2), 1);
    chk("d2_full", int'(full2), 1);
    chk("d2_cnt", int'(cnt2), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_fifo_ptr_ctrl.md
# tx_fifo_ptr_ctrl

Parametrised head/tail pointer controller for the transmit-side FIFOs. Generalises the single tail counter into a full pointer pair of arbitrary (including non-power-of-two) depth, with wrap toggle bits, occupancy count, full/empty and threshold flags, synchronous flush and sticky overflow/underflow detection. It drives the write/read addresses and enables of the TX buffer RAM and gives back-pressure status to the packet assembler and the serialiser.

## Interface
Parameters:
- DEPTH, 6: number of FIFO entries, 2..256, need not be a power of two.
- PTR_W, $clog2(DEPTH): pointer width.
- CNT_W, $clog2(DEPTH+1): occupancy width.
- AF_THRESH, DEPTH-1: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush.
- tx_enq  in  1  enqueue request.
- tx_deq  in  1  dequeue request.
- enq_ok  out  1  enqueue accepted this cycle (RAM write enable).
- deq_ok  out  1  dequeue accepted this cycle (RAM read advance).
- tail_ptr  out  PTR_W  write address.
- tail_tog  out  1  tail wrap parity.
- head_ptr  out  PTR_W  read address.
- head_tog  out  1  head wrap parity.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- Reset (rst high, asynchronous): tail_ptr=0, head_ptr=0, both toggles=0, count=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1 (AE_THRESH>=0), almost_full=0.
- Acceptance (combinational): enq_ok = tx_enq & ~full & ~clear; deq_ok = tx_deq & ~empty & ~clear. Status is evaluated on current registered state; a dequeue in the same cycle does not free space for an enqueue when full.
- Pointer advance: on enq_ok, tail_ptr increments; at DEPTH-1 it wraps to 0 and tail_tog inverts. Same for head_ptr/head_tog on deq_ok. Pointer values never reach DEPTH..2^PTR_W-1.
- count: +1 on enq_ok only, -1 on deq_ok only, unchanged when both or neither.
- Flags, derived from registered state: empty = (head_ptr==tail_ptr) & (head_tog==tail_tog); full = (head_ptr==tail_ptr) & (head_tog!=tail_tog). count must always equal the pointer distance; count==0 iff empty and count==DEPTH iff full.
- Errors: overflow sets on tx_enq & full & ~clear; underflow sets on tx_deq & empty & ~clear. Both hold until clear or rst.
- clear: highest priority after rst. On the next edge it returns all state, including the error flags, to reset values. tx_enq/tx_deq in that cycle are ignored and set no error.

## Timing
- enq_ok/deq_ok are combinational, valid in the request cycle.
- Pointers, toggles, count and error flags update on the rising edge that samples the accepted request. Status flags reflect the new state immediately after that edge (1-cycle latency from request to flag).
- tail_ptr during the enq_ok cycle is the write address for that entry. head_ptr during the deq_ok cycle is the read address.
- rst asserted mid-operation clears all state immediately, independent of clk.
- No combinational path from tx_enq to full or from tx_deq to empty.

## Test plan
- Reset then fill, DEPTH=6: six tx_enq pulses. Required: tail_ptr 0,1,2,3,4,5,0; tail_tog flips to 1 after the 6th; full=1; count=6; almost_full=1 from count=5.
- Overflow: while full, assert tx_enq for 1 cycle. Required: enq_ok=0, tail_ptr unchanged, overflow=1 and it stays 1. Then assert clear. Required: overflow=0, empty=1, all pointers 0.
- Drain and underflow: from full, issue seven tx_deq. Required: head wraps 5->0 with head_tog=1; empty after the 6th; 7th gives deq_ok=0 and underflow=1.
- Simultaneous: at count=3, assert tx_enq and tx_deq together for 4 cycles. Required: count stays 3; both pointers advance by 4 mod 6; toggles flip once each.
- Edge simultaneity: at empty, enq+deq together. Required: enq_ok=1, deq_ok=0, count=1. At full, enq+deq together. Required: deq_ok=1, enq_ok=0, overflow=1, count=5.
- Async reset mid-traffic: assert rst between clock edges at count=4. Required: all outputs reach reset values before the next edge. Repeat the fill test with DEPTH=8 and DEPTH=2 for wrap and toggle correctness.
